// File: rtl/modn_counter.sv
// Modulo-N up/down counter with clear, range-checked load, wrap/saturate mode
// and a combinational terminal count for cascading stages.
module modn_counter #(
    parameter int MODULUS  = 6,
    parameter int WIDTH    = 3,
    parameter int SATURATE = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_q,
    output logic             o_tc,
    output logic             o_wrap,
    output logic             o_load_err
);

    generate
        if (MODULUS < 2 || (64'(MODULUS) > (64'd1 << WIDTH))) begin : g_bad_params
            $error("modn_counter: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    // Range compares use WIDTH+1 bits so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_load_err;

    logic [WIDTH-1:0] w_q_nxt;
    logic             w_wrap_nxt;
    logic             w_err_nxt;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_q_ill;
    logic             w_ld_ok;

    assign w_at_max = (r_q == MAXV);
    assign w_at_min = (r_q == '0);
    assign w_q_ill  = ({1'b0, r_q} >= MOD_X);
    assign w_ld_ok  = ({1'b0, i_load_val} < MOD_X);

    always_comb begin
        w_q_nxt    = r_q;
        w_wrap_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        if (i_clr) begin
            w_q_nxt = '0;
        end else if (i_load) begin
            if (w_ld_ok) w_q_nxt   = i_load_val;
            else         w_err_nxt = 1'b1;
        end else if (i_en) begin
            // Boundary is tested before stepping, so +1/-1 never needs a carry bit.
            if (w_q_ill) begin
                w_q_nxt = '0;
            end else if (i_up) begin
                if (!w_at_max) begin
                    w_q_nxt = r_q + 1'b1;
                end else if (SATURATE == 0) begin
                    w_q_nxt    = '0;
                    w_wrap_nxt = 1'b1;
                end
            end else begin
                if (!w_at_min) begin
                    w_q_nxt = r_q - 1'b1;
                end else if (SATURATE == 0) begin
                    w_q_nxt    = MAXV;
                    w_wrap_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_q        <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_q        <= w_q_nxt;
            r_wrap     <= w_wrap_nxt;
            r_load_err <= w_err_nxt;
        end
    end

    assign o_q        = r_q;
    assign o_wrap     = r_wrap;
    assign o_load_err = r_load_err;
    assign o_tc       = i_en & ((i_up & w_at_max) | (~i_up & w_at_min));

endmodule

// File: doc/modn_counter.md
Name: modn_counter

Overview:
Parametrised synchronous modulo-N up/down counter, the general successor to the fixed modulo-6 counter. Adds:
- run-time direction
- synchronous clear and parallel load, with load range checking
- wrap or saturate mode
- terminal-count output for cascading counter stages (e.g. seconds/minutes dividers)

Sits in the seq_logic library as the standard counter primitive for dividers and timers.

Parameters:
MODULUS, 6, number of states; count range 0..MODULUS-1; legal range 2..2^WIDTH
WIDTH, 3, counter width in bits; elaboration must fail (generate-time check) if 2^WIDTH < MODULUS
SATURATE, 0, 0 = wrap at boundaries; 1 = hold at boundary value

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  count enable; qualifies stepping only
clr  input  1  synchronous clear to 0
load  input  1  synchronous parallel load
load_val  input  WIDTH  value for load
up  input  1  direction: 1 = increment, 0 = decrement
q  output  WIDTH  current count
tc  output  1  combinational terminal count, for cascading into the next stage's en
wrap  output  1  registered one-cycle pulse: counter wrapped on the previous edge
load_err  output  1  registered one-cycle pulse: previous load was out of range

Behaviour:
- Reset (asynchronous, active-high): q = 0, wrap = 0, load_err = 0 immediately, without waiting for a clock edge; held while reset = 1.
- Priority at each rising clk edge, reset deasserted: clr > load > en step > hold.
- clr = 1: q <= 0. wrap <= 0, load_err <= 0. Acts regardless of en.
- load = 1 (clr = 0), acts regardless of en:
  - load_val < MODULUS: q <= load_val, load_err <= 0.
  - load_val >= MODULUS: q unchanged, load_err <= 1 for one cycle.
  - wrap <= 0 in both cases.
- en = 1 (clr = load = 0):
  - up = 1, q < MODULUS-1: q <= q+1.
  - up = 1, q = MODULUS-1: SATURATE = 0 gives q <= 0, wrap <= 1. SATURATE = 1 gives q holds, wrap <= 0.
  - up = 0, q > 0: q <= q-1.
  - up = 0, q = 0: SATURATE = 0 gives q <= MODULUS-1, wrap <= 1. SATURATE = 1 gives q holds, wrap <= 0.
- en = 0 (no clr/load): q holds. wrap <= 0, load_err <= 0.
- wrap and load_err are single-cycle pulses: deasserted on any edge that does not re-trigger them.
- tc = en & ((up & q == MODULUS-1) | (~up & q == 0)).
  - Purely combinational; asserts in saturate mode too.
  - Not gated by clr/load.
- Illegal state q >= MODULUS (unreachable except by fault injection): next en step forces q <= 0 in either direction, wrap <= 0.
- No arithmetic overflow: compute next value at WIDTH bits. The boundary compare happens before +1/-1, so 2^WIDTH = MODULUS still wraps correctly.
- up may change on any cycle; it takes effect on the same edge.
- Reset asserted mid-count: q returns to 0 asynchronously. The first edge after deassert applies normal priority.

Test Plan:
1. Default params, en = 1, up = 1 from reset for 8 edges -> q = 1,2,3,4,5,0,1,2. wrap high the cycle after q goes 5->0. tc high while q = 5.
2. up = 0 from q = 0, en = 1, 3 edges -> q = 5,4,3. wrap pulses once after 0->5. tc high at q = 0.
3. Load tests (MODULUS = 6): load = 1, load_val = 4 -> q = 4, load_err = 0. load_val = 7 -> q stays 4, load_err = 1 for one cycle. Simultaneous clr = 1, load = 1, load_val = 3 -> q = 0.
4. SATURATE = 1, MODULUS = 10, WIDTH = 4, up = 1 from q = 8, 4 edges -> q = 9,9,9,9. wrap never asserts. tc = 1 while q = 9 and en = 1. Then up = 0 -> q = 8.
5. Assert reset between edges while q = 3 -> q = 0 before the next edge. en = 0 with toggling up -> q holds, tc = 0.
6. Cascade two instances (MODULUS = 10 units, MODULUS = 6 tens; tens.en = units.tc), 60 edges with units.en = 1 -> tens increments every 10 edges. Both wrap to 0/0 at edge 60.
